// File: rtl/ysyx22041405_exu_pkg.sv
// Shared EXU definitions: M-extension op codes (funct3), FSM states, one-hot ALU control bits.
package ysyx22041405_exu_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MD_BUSY = 2'd1,
    S_RESULT  = 2'd2
  } exu_state_e;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;
  localparam int ALU_EQ   = 10;
  localparam int ALU_NE   = 11;
  localparam int ALU_GE   = 12;
  localparam int ALU_GEU  = 13;

endpackage

// File: rtl/ysyx22041405_alu.sv
// Single-cycle integer ALU driven by a one-hot control vector; lowest set bit wins.
module ysyx22041405_alu
  import ysyx22041405_exu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALU_CTRL_W = 14
) (
  input  logic [WIDTH-1:0]      i_src1,
  input  logic [WIDTH-1:0]      i_src2,
  input  logic [ALU_CTRL_W-1:0] i_ctrl,
  output logic [WIDTH-1:0]      o_result
);

  localparam int SHW = (WIDTH == 64) ? 6 : 5;

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_src2[SHW-1:0];

  always_comb begin
    o_result = '0;
    if      (i_ctrl[ALU_ADD])  o_result = i_src1 + i_src2;
    else if (i_ctrl[ALU_SUB])  o_result = i_src1 - i_src2;
    else if (i_ctrl[ALU_SLL])  o_result = i_src1 << w_shamt;
    else if (i_ctrl[ALU_SLT])  o_result = {{(WIDTH-1){1'b0}}, $signed(i_src1) < $signed(i_src2)};
    else if (i_ctrl[ALU_SLTU]) o_result = {{(WIDTH-1){1'b0}}, i_src1 < i_src2};
    else if (i_ctrl[ALU_XOR])  o_result = i_src1 ^ i_src2;
    else if (i_ctrl[ALU_SRL])  o_result = i_src1 >> w_shamt;
    else if (i_ctrl[ALU_SRA])  o_result = $unsigned($signed(i_src1) >>> w_shamt);
    else if (i_ctrl[ALU_OR])   o_result = i_src1 | i_src2;
    else if (i_ctrl[ALU_AND])  o_result = i_src1 & i_src2;
    else if (i_ctrl[ALU_EQ])   o_result = {{(WIDTH-1){1'b0}}, i_src1 == i_src2};
    else if (i_ctrl[ALU_NE])   o_result = {{(WIDTH-1){1'b0}}, i_src1 != i_src2};
    else if (i_ctrl[ALU_GE])   o_result = {{(WIDTH-1){1'b0}}, $signed(i_src1) >= $signed(i_src2)};
    else if (i_ctrl[ALU_GEU])  o_result = {{(WIDTH-1){1'b0}}, i_src1 >= i_src2};
  end

endmodule

// File: rtl/ysyx22041405_mdu.sv
// Iterative multiply/divide: WIDTH steps on magnitudes through one shared adder, sign fix-up on the way out.
module ysyx22041405_mdu
  import ysyx22041405_exu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy, r_neg_q, r_neg_r, r_dz;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_m, r_lo, r_a;
  logic [WIDTH:0]   r_hi;

  logic             w_mul, w_a_neg, w_b_neg, w_is_mul, w_neg;
  logic [WIDTH-1:0] w_ma, w_mb, w_q, w_r;
  logic [WIDTH+1:0] w_op_a, w_op_b, w_sum;
  logic [WIDTH:0]   w_t;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_mul   = ~i_op[2];
  assign w_a_neg = i_a[WIDTH-1] & (i_op == MD_MULH || i_op == MD_MULHSU || i_op == MD_DIV || i_op == MD_REM);
  assign w_b_neg = i_b[WIDTH-1] & (i_op == MD_MULH || i_op == MD_DIV || i_op == MD_REM);
  assign w_ma    = w_a_neg ? -i_a : i_a;
  assign w_mb    = w_b_neg ? -i_b : i_b;

  // mul: hi += multiplicand; div: (hi:lo msb) - divisor via inverted operand + carry-in
  assign w_is_mul = ~r_op[2];
  assign w_op_a   = w_is_mul ? {1'b0, r_hi} : {1'b0, r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_op_b   = w_is_mul ? {2'b0, r_m} : ~{2'b0, r_m};
  assign w_sum    = w_op_a + w_op_b + {{(WIDTH+1){1'b0}}, ~w_is_mul};
  assign w_t      = r_lo[0] ? w_sum[WIDTH:0] : r_hi;
  assign w_neg    = w_sum[WIDTH+1];

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(WIDTH-1));

  assign w_prod   = {r_hi[WIDTH-1:0], r_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -r_lo : r_lo;
  assign w_r      = r_neg_r ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];

  always_comb begin
    o_result = '0;
    case (r_op)
      MD_MUL:                     o_result = w_prod_s[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_s[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:            o_result = r_dz ? '1 : w_q;
      default:                    o_result = r_dz ? r_a : w_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0; r_cnt <= '0; r_op <= '0; r_m <= '0; r_lo <= '0; r_hi <= '0;
      r_a <= '0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_dz <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_op    <= i_op;
      r_a     <= i_a;
      r_hi    <= '0;
      r_lo    <= w_mul ? w_mb : w_ma;
      r_m     <= w_mul ? w_ma : w_mb;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (i_b == '0);
    end else if (r_busy) begin
      if (w_is_mul) begin
        r_hi <= {1'b0, w_t[WIDTH:1]};
        r_lo <= {w_t[0], r_lo[WIDTH-1:1]};
      end else begin
        r_hi <= w_neg ? w_op_a[WIDTH:0] : w_sum[WIDTH:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_neg};
      end
      r_cnt <= r_cnt + CW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/ysyx22041405_exu_pipe.sv
// EXU stage: ALU in one cycle, M-extension ops in WIDTH+1 cycles when YSYX22041405_EXU_MDU_EN is defined.
module ysyx22041405_exu_pipe
  import ysyx22041405_exu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALU_CTRL_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_rdata1,
  input  logic [WIDTH-1:0]      in_rdata2,
  input  logic [WIDTH-1:0]      imm,
  input  logic [WIDTH-1:0]      pc,
  input  logic [4:0]            in_rd,
  input  logic                  in_we,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic                  s1_sel,
  input  logic                  s2_sel,
  input  logic                  is_lui,
  input  logic                  is_md,
  input  logic [2:0]            md_op,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [4:0]            out_rd,
  output logic                  out_we,
  output logic [WIDTH-1:0]      out_pc,
  output logic                  busy,
  output logic                  nsupport
);

  exu_state_e       r_state;
  logic             r_md_res;
  logic [WIDTH-1:0] r_alu_res;
  logic [WIDTH-1:0] w_src1, w_src2, w_alu_res, w_mdu_res;
  logic             w_accept, w_md_acc, w_md_done, w_unsup;

  assign w_src1 = s1_sel ? (is_lui ? '0 : pc) : in_rdata1;
  assign w_src2 = s2_sel ? imm : in_rdata2;

  ysyx22041405_alu #(.WIDTH(WIDTH), .ALU_CTRL_W(ALU_CTRL_W)) u_alu (
    .i_src1(w_src1), .i_src2(w_src2), .i_ctrl(alu_ctrl), .o_result(w_alu_res)
  );

  assign out_valid  = (r_state == S_RESULT);
  assign in_ready   = (r_state != S_MD_BUSY) && (!out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && in_ready;
  // MDU registers hold their final value until the next start, so the result is read straight out
  assign out_result = r_md_res ? w_mdu_res : r_alu_res;

`ifdef YSYX22041405_EXU_MDU_EN
  logic w_mdu_busy;
  ysyx22041405_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk), .rst(rst), .i_start(w_accept && is_md), .i_abort(flush), .i_op(md_op),
    .i_a(in_rdata1), .i_b(in_rdata2), .o_busy(w_mdu_busy), .o_done(w_md_done), .o_result(w_mdu_res)
  );
  assign w_md_acc = is_md;
  assign w_unsup  = 1'b0;
  assign busy     = (r_state == S_MD_BUSY) && w_mdu_busy;
`else
  logic w_unused_md;
  assign w_unused_md = ^md_op;
  assign w_mdu_res   = '0;
  assign w_md_done   = 1'b0;
  assign w_md_acc    = 1'b0;
  assign w_unsup     = is_md;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_alu_res <= '0;
      r_md_res  <= 1'b0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      out_pc    <= '0;
      nsupport  <= 1'b0;
    end else begin
      nsupport <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else if (w_accept) begin
        out_rd   <= in_rd;
        out_we   <= in_we && !w_unsup;
        out_pc   <= pc;
        r_md_res <= 1'b0;
        if (w_md_acc) begin
          r_state <= S_MD_BUSY;
        end else begin
          r_state   <= S_RESULT;
          r_alu_res <= w_unsup ? '0 : w_alu_res;
          nsupport  <= w_unsup;
        end
      end else if (r_state == S_MD_BUSY && w_md_done) begin
        r_state  <= S_RESULT;
        r_md_res <= 1'b1;
      end else if (r_state == S_RESULT && out_ready) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ysyx22041405_exu_pipe.sv
// Scoreboard bench for ysyx22041405_exu_pipe; MD checks depend on YSYX22041405_EXU_MDU_EN.
module tb_ysyx22041405_exu_pipe;
  import ysyx22041405_exu_pkg::*;

  localparam int W  = 32;
  localparam int CW = 14;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_valid, in_ready, in_we, s1_sel, s2_sel, is_lui, is_md, flush;
  logic          out_valid, out_ready, out_we, busy, nsupport;
  logic [W-1:0]  in_rdata1, in_rdata2, imm, pc, out_result, out_pc;
  logic [4:0]    in_rd, out_rd;
  logic [CW-1:0] alu_ctrl;
  logic [2:0]    md_op;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         we;
    logic [W-1:0] pc;
    int           lat;
    int           pcyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0, cyc = 0;
  bit   seen = 0;

  ysyx22041405_exu_pipe #(.WIDTH(W), .ALU_CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .imm(imm), .pc(pc),
    .in_rd(in_rd), .in_we(in_we), .alu_ctrl(alu_ctrl), .s1_sel(s1_sel),
    .s2_sel(s2_sel), .is_lui(is_lui), .is_md(is_md), .md_op(md_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_pc(out_pc), .busy(busy), .nsupport(nsupport)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return W'($signed(a) < $signed(b));
      ALU_SLTU: return W'(a < b);
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return W'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_EQ:   return W'(a == b);
      ALU_NE:   return W'(a != b);
      ALU_GE:   return W'($signed(a) >= $signed(b));
      default:  return W'(a >= b);
    endcase
  endfunction

`ifdef YSYX22041405_EXU_MDU_EN
  function automatic logic [W-1:0] md_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? '1 : ovf ? a : W'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: return (b == 0) ? a : ovf ? '0 : W'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
`endif

  task automatic defaults();
    alu_ctrl = '0; alu_ctrl[ALU_ADD] = 1'b1;
    s1_sel = 0; s2_sel = 0; is_lui = 0; is_md = 0; md_op = '0; in_we = 1;
    in_rdata1 = $urandom; in_rdata2 = $urandom; imm = $urandom; pc = $urandom; in_rd = 5'($urandom);
  endtask

  task automatic send(input logic [W-1:0] eres, input logic ewe, input int elat, output int waited);
    exp_t e;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin waited++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else begin
      e.res = eres; e.rd = in_rd; e.we = ewe; e.pc = pc; e.lat = elat; e.pcyc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    defaults();
    alu_ctrl = '0; alu_ctrl[op] = 1'b1;
    in_rdata1 = a; in_rdata2 = b;
    send(alu_ref(op, a, b), 1'b1, 1, waited);
  endtask

  task automatic md_send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eres, output int waited);
    defaults();
    is_md = 1'b1; md_op = op; in_rdata1 = a; in_rdata2 = b;
`ifdef YSYX22041405_EXU_MDU_EN
    send(eres, 1'b1, W + 1, waited);
`else
    send('0, 1'b0, 1, waited);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin n++; @(negedge clk); end
    chk("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_res"}, out_result, 0);
    chk({tag, "_rd"}, out_rd, 0);
    chk({tag, "_we"}, out_we, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nsup"}, nsupport, 0);
  endtask

  // Scoreboard: every cycle out_valid is up the head entry must match; pop on handshake
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sbq.size() == 0) chk("stray_valid", out_valid, 0);
      else begin
        if (!seen) begin chk("latency", 64'(cyc - sbq[0].pcyc), 64'(sbq[0].lat)); seen = 1; end
        chk("result", out_result, sbq[0].res);
        chk("rd", out_rd, sbq[0].rd);
        chk("we", out_we, sbq[0].we);
        chk("pc", out_pc, sbq[0].pc);
        if (out_ready) begin void'(sbq.pop_front()); seen = 0; end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    in_valid = 0; flush = 0; out_ready = 1;
    defaults();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1; rst = 1;

    // ADDI with a 3-cycle output stall
    defaults();
    in_rdata1 = 5; imm = 7; s2_sel = 1; out_ready = 0;
    send(32'd12, 1'b1, 1, w);
    for (int k = 0; k < 3; k++) begin @(negedge clk); chk("hold_inrdy", in_ready, 0); end
    @(posedge clk); #1; out_ready = 1;
    drain();

    // back-to-back ALU ops
    for (int i = 0; i < 14; i++) begin
      alu_op(i, $urandom, (i % 3 == 0) ? 32'h8000_001F : $urandom, w);
      chk("b2b_nobubble", w, 0);
    end
    alu_op(ALU_SRA, 32'h8000_0000, 32'd31, w); chk("b2b_nobubble", w, 0);
    alu_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, w);  chk("b2b_nobubble", w, 0);
    defaults(); s1_sel = 1; is_lui = 1; s2_sel = 1; imm = 32'h1234_5000;
    send(32'h1234_5000, 1'b1, 1, w); chk("b2b_nobubble", w, 0);
    defaults(); s1_sel = 1; s2_sel = 1; pc = 32'h8000_0000; imm = 32'h1000;
    send(32'h8000_1000, 1'b1, 1, w); chk("b2b_nobubble", w, 0);
    drain();

    // flush a held ALU result
    out_ready = 0;
    alu_op(ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, w);
    @(negedge clk);
    @(posedge clk); #1; flush = 1;
    @(negedge clk); chk("flush_inrdy", in_ready, 0);
    @(posedge clk); #1;
    void'(sbq.pop_front()); seen = 0; flush = 0; out_ready = 1;
    chk("flush_clr", out_valid, 0);
    alu_op(ALU_SUB, 32'd100, 32'd1, w);
    drain();

    // async reset while a result is held, accept right after release
    out_ready = 0;
    alu_op(ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, w);
    @(negedge clk); #2; rst = 0; #1;
    chk_zero("rst_hold");
    void'(sbq.pop_front()); seen = 0; out_ready = 1;
    @(posedge clk); #1; rst = 1;
    alu_op(ALU_ADD, 32'd40, 32'd2, w);
    chk("rst_first_acc", w, 0);
    drain();

`ifdef YSYX22041405_EXU_MDU_EN
    md_send(MD_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, w);
    for (int k = 0; k < W; k++) begin
      @(negedge clk); chk("mul_busy", busy, 1); chk("mul_inrdy", in_ready, 0);
    end
    drain();
    md_send(MD_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, w);
    md_send(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, w);
    md_send(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, w);
    md_send(MD_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, w);
    md_send(MD_REMU, 32'd10, 32'd0, 32'd10, w);
    md_send(MD_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, w);
    md_send(MD_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, w);
    md_send(MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, w);
    for (int i = 0; i < 8; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'(i);
      a  = $urandom;
      b  = (i % 2) ? $urandom : 32'($urandom_range(1, 300));
      md_send(op, a, b, md_ref(op, a, b), w);
    end
    drain();

    // flush at cycle 10 of a DIV together with a new op
    md_send(MD_DIV, 32'd1000, 32'd7, 32'd142, w);
    repeat (9) @(posedge clk);
    #1; flush = 1;
    defaults(); in_valid = 1; in_rdata1 = 32'hDEAD; in_rdata2 = 32'h1;
    @(negedge clk); chk("fl_div_inrdy", in_ready, 0); chk("fl_div_busy", busy, 1);
    @(posedge clk); #1;
    void'(sbq.pop_front()); seen = 0; flush = 0; in_valid = 0;
    chk("fl_div_vld", out_valid, 0); chk("fl_div_busy0", busy, 0);
    alu_op(ALU_ADD, 32'd21, 32'd21, w);
    chk("fl_div_next", w, 0);
    drain();
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    // async reset mid-MUL
    md_send(MD_MUL, 32'd3, 32'd5, 32'd15, w);
    repeat (5) @(posedge clk);
    @(negedge clk); #2; rst = 0; #1;
    chk_zero("rst_mul");
    void'(sbq.pop_front()); seen = 0;
    @(posedge clk); #1; rst = 1;
    alu_op(ALU_ADD, 32'd7, 32'd8, w);
    chk("rst_mul_acc", w, 0);
    drain();
    repeat (40) @(negedge clk);
`else
    md_send(MD_MUL, 32'hFFFF_FFFF, 32'd2, 32'h0, w);
    @(negedge clk); chk("nsup_pulse", nsupport, 1); chk("nsup_busy", busy, 0);
    @(negedge clk); chk("nsup_clr", nsupport, 0);
    drain();
    md_send(MD_DIV, 32'd10, 32'd3, 32'h0, w);
    @(negedge clk); chk("nsup_pulse2", nsupport, 1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx22041405_exu_pipe.md
YSYX22041405_EXU_PIPE -- requirements
Module: ysyx22041405_exu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath/register width; legal values are 32 and 64.
REQ-002 SHALL have parameter ALU_CTRL_W, default 14, meaning the one-hot ALU control width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the ID stage presents an operation.
REQ-006 SHALL have port in_ready, output, 1 bit: the EXU accepts the operation this cycle.
REQ-007 SHALL have port in_rdata1, in_rdata2, imm and pc, each input, WIDTH bits: register operands, immediate and PC.
REQ-008 SHALL have port in_rd, input, 5 bits, and in_we, input, 1 bit: destination register and write enable.
REQ-009 SHALL have port alu_ctrl, input, ALU_CTRL_W bits, plus s1_sel, s2_sel and is_lui, each input, 1 bit: operand selects.
REQ-010 SHALL have port is_md, input, 1 bit, and md_op, input, 3 bits: M-extension operation using the funct3 encoding.
REQ-011 SHALL have port flush, input, 1 bit: kill the in-flight operation.
REQ-012 SHALL have port out_valid, input ready out_ready, plus outputs out_result (WIDTH), out_rd (5), out_we (1) and out_pc (WIDTH).
REQ-013 SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-014 SHALL have port nsupport, output, 1 bit: a one-cycle pulse on acceptance of an unsupported operation.

Function
REQ-015 SHALL select src1 = s1_sel ? (is_lui ? 0 : pc) : in_rdata1, and src2 = s2_sel ? imm : in_rdata2.
REQ-016 SHALL implement the state machine IDLE -> (accept, is_md=1) MD_BUSY -> (done) RESULT; IDLE -> (accept, is_md=0) RESULT; RESULT -> (out_ready, no accept) IDLE; RESULT -> (out_ready and accept) RESULT or MD_BUSY.
REQ-017 SHALL drive in_ready = (state != MD_BUSY) && (!out_valid || out_ready) && !flush.
REQ-018 SHALL register an ALU result one cycle after acceptance, so that out_valid rises in the next cycle.
REQ-019 SHALL compute MUL/MULH/MULHSU/MULHU by iterative shift-add over WIDTH cycles, with out_valid asserted at WIDTH+1 cycles after acceptance.
REQ-020 SHALL compute DIV/DIVU/REM/REMU by restoring division over WIDTH cycles, with out_valid asserted at WIDTH+1 cycles after acceptance.
REQ-021 SHALL, on a divide by zero, return quotient all-ones and remainder = dividend, with the same latency as a normal divide.
REQ-022 SHALL, on signed overflow (-2^(WIDTH-1) / -1), return quotient = dividend and remainder = 0.
REQ-023 SHALL hold the out_* signals stable while out_valid && !out_ready.
REQ-024 SHALL, on flush, go to IDLE next cycle, clear out_valid, abort the MDU and suppress any result.
REQ-025 SHALL give flush priority over a simultaneous in_valid; that operation is not accepted.
REQ-026 SHALL compute 64-bit products internally as 2*WIDTH and take the upper half for the MULH* operations.

Reset
REQ-027 SHALL, while rst=0, drive state=IDLE, out_valid=0, out_result=0, out_rd=0, out_we=0, out_pc=0, busy=0, nsupport=0 and clear the MDU counters.
REQ-028 SHALL, when reset asserts mid-MD_BUSY, discard the partial result immediately; the first accept is possible in the first cycle after release.

Configuration
REQ-029 SHALL use the macro YSYX22041405_EXU_MDU_EN.
REQ-030 SHALL, with YSYX22041405_EXU_MDU_EN defined, instantiate the MDU and honour is_md.
REQ-031 SHALL, without YSYX22041405_EXU_MDU_EN, not instantiate the MDU; an accepted is_md op completes in one cycle with out_result=0, out_we=0 and a nsupport pulse, and busy stays 0.

Structure
REQ-032 SHALL place in package ysyx22041405_exu_pkg the md_op encodings (MUL=0 ... REMU=7), the FSM state typedef and the ALU control bit indices.
REQ-033 SHALL contain one sub-module, ysyx22041405_mdu: start/done handshake, WIDTH-cycle counter, shared shift-add/subtract datapath.
REQ-034 SHALL reuse the existing ALU as an instance and SHALL not duplicate it.

Verification
REQ-035 SHALL cover ADDI: rdata1=5, imm=7, s2_sel=1 -> out_valid one cycle later, out_result=12, held while out_ready=0 for 3 cycles.
REQ-036 SHALL cover MUL: 0xFFFFFFFF*2 -> out_result=0xFFFFFFFE after 33 cycles, MULHU -> 0x00000001, busy=1 throughout, in_ready=0.
REQ-037 SHALL cover DIV: 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 10/0 -> 0xFFFFFFFF, REMU 10/0 -> 10.
REQ-038 SHALL cover flush at cycle 10 of a DIV plus in_valid the same cycle -> no out_valid, that op not accepted, a new ADD accepted next cycle and its result correct.
REQ-039 SHALL cover back-to-back ALU ops with out_ready=1 -> one result per cycle, no bubbles, and rst dropped mid-MUL -> all outputs 0 asynchronously.
REQ-040 SHALL cover a build without YSYX22041405_EXU_MDU_EN: MUL accepted -> nsupport pulse, out_we=0, latency 1.
